// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: arbiter-PUF sequencer; fires each challenge NUM_EVAL times,
// majority-votes the synchronized response and flags bits on which every evaluation agreed.
module puf_eval_ctrl #(
   parameter int NUM_EVAL   = 7,
   parameter int SETTLE_CYC = 4,
   parameter int PULSE_CYC  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] challenge,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic [7:0] stable,
   output logic [7:0] puf_challenge,
   output logic       puf_pulse,
   input  logic [7:0] puf_response
);
   localparam int EW = $clog2(NUM_EVAL + 1);
   localparam int CW = 16;

   typedef enum logic [2:0] {IDLE, SETUP, FIRE, CAPTURE, RELAX, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [EW-1:0] ev;
   logic [EW-1:0] ones [8];
   logic [7:0]    sync1, sync2, vote, agree;
   logic          last;

   always_comb begin
      vote  = '0;
      agree = '0;
      for (int i = 0; i < 8; i++) begin
         vote[i]  = ones[i] > EW'(NUM_EVAL / 2);
         agree[i] = ones[i] == '0 || ones[i] == EW'(NUM_EVAL);
      end
   end

   // last cycle of the current phase; DONE always lasts a single cycle
   always_comb
      last = (state == SETUP || state == RELAX) ? cnt == CW'(SETTLE_CYC - 1) :
             (state == FIRE)    ? cnt == CW'(PULSE_CYC - 1) :
             (state == CAPTURE) ? cnt == CW'(2) : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= puf_response;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         ev            <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= '0;
         stable        <= '0;
         puf_challenge <= '0;
         puf_pulse     <= 1'b0;
         for (int i = 0; i < 8; i++) ones[i] <= '0;
      end else begin
         done <= 1'b0;
         cnt  <= last ? '0 : cnt + CW'(1);
         if (state == IDLE) begin
            cnt <= '0;
            if (start) begin
               state         <= SETUP;
               puf_challenge <= challenge;
               ev            <= '0;
               busy          <= 1'b1;
               for (int i = 0; i < 8; i++) ones[i] <= '0;
            end
         end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            puf_pulse <= 1'b0;
         end else if (last) begin
            case (state)
               SETUP: begin
                  state     <= FIRE;
                  puf_pulse <= 1'b1;
               end
               FIRE: begin
                  state     <= CAPTURE;
                  puf_pulse <= 1'b0;
               end
               CAPTURE: begin
                  state <= RELAX;
                  ev    <= ev + EW'(1);
                  for (int i = 0; i < 8; i++) ones[i] <= ones[i] + EW'(sync2[i]);
               end
               RELAX: begin
                  if (ev < EW'(NUM_EVAL)) begin
                     state     <= FIRE;
                     puf_pulse <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     result <= vote;
                     stable <= agree;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: randomized requests checked every cycle against an arithmetic
// schedule/vote model, plus literal pins for the documented scenarios.
module tb_puf_eval_ctrl;
   localparam int N = 7, S = 4, P = 2, E = P + 3 + S, T = S + N * E;

   logic       clk = 0, rst_n = 0, start = 0, abort = 0;
   logic [7:0] challenge = 0, puf_response = 0;
   logic       busy, done, puf_pulse;
   logic [7:0] result, stable, puf_challenge;

   logic       start1 = 0;
   logic [7:0] resp1 = 8'h5A;
   logic       busy1, done1, pulse1;
   logic [7:0] result1, stable1, chal1;

   puf_eval_ctrl #(.NUM_EVAL(N), .SETTLE_CYC(S), .PULSE_CYC(P)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .challenge(challenge),
      .busy(busy), .done(done), .result(result), .stable(stable),
      .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_response(puf_response));

   puf_eval_ctrl #(.NUM_EVAL(1), .SETTLE_CYC(1), .PULSE_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .challenge(8'h77),
      .busy(busy1), .done(done1), .result(result1), .stable(stable1),
      .puf_challenge(chal1), .puf_pulse(pulse1), .puf_response(resp1));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   logic chk_en = 0;
   logic e_busy = 0, e_done = 0, e_pulse = 0;
   logic [7:0] e_res = 0, e_stab = 0, e_chal = 0, m_res = 0, m_stab = 0, m_chal = 0;
   int k_cur = -1, last_done_k = -1, pulse_cnt = 0, done_cnt = 0;
   logic prev_pulse = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("puf_pulse", puf_pulse, e_pulse);
      chk("result", result, e_res);
      chk("stable", stable, e_stab);
      chk("puf_challenge", puf_challenge, e_chal);
      if (done) begin
         last_done_k = k_cur;
         done_cnt++;
      end
      if (puf_pulse && !prev_pulse) pulse_cnt++;
      prev_pulse = puf_pulse;
   end

   task automatic set_idle();
      k_cur = -1; e_busy = 0; e_done = 0; e_pulse = 0;
      e_res = m_res; e_stab = m_stab; e_chal = m_chal;
   endtask

   // kind: 0 = run to completion, 1 = abort at cycle kill_at, 2 = reset at cycle kill_at
   task automatic run_req(input logic [7:0] c, input logic [7:0] vals [N], input int kind,
                          input int kill_at, input bit noise);
      logic [7:0] r, s;
      int cb;
      for (int b = 0; b < 8; b++) begin
         cb = 0;
         for (int j = 0; j < N; j++) cb += int'(vals[j][b]);
         r[b] = 2 * cb > N;
         s[b] = cb == 0 || cb == N;
      end
      pulse_cnt = 0; done_cnt = 0; last_done_k = -1;
      start = 1; challenge = c; abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 0; m_chal = c;
      for (int k = 0; k <= T; k++) begin
         k_cur = k;
         e_busy = k < T; e_done = k == T;
         e_pulse = k >= S && k < T && (k - S) % E < P;
         if (k == T) begin
            m_res = r; m_stab = s;
         end
         e_res = m_res; e_stab = m_stab; e_chal = m_chal;
         if (k >= S && k < T && (k - S) % E == 0) puf_response = vals[(k - S) / E];
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            challenge = 8'($urandom);
         end
         abort = kind == 1 && k == kill_at;
         if (kind == 2 && k == kill_at) begin
            #1;
            m_res = 0; m_stab = 0; m_chal = 0;
            set_idle();
            rst_n = 0;
            #1;
            chk("rst_pulse", puf_pulse, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result", result, 0);
            chk("rst_stable", stable, 0);
            chk("rst_chal", puf_challenge, 0);
            start = 0;
            @(posedge clk); #1;
            rst_n = 1;
            return;
         end
         @(posedge clk); #1;
         if (kind == 1 && k == kill_at) begin
            abort = 0; start = 0;
            set_idle();
            @(posedge clk); #1;
            return;
         end
      end
      start = 0;
      set_idle();
   endtask

   task automatic idle_abort();
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      @(posedge clk); #1;
   endtask

   logic [7:0] v [N];
   int k1;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_pulse", puf_pulse, 0);
      chk("reset_result", result, 0);
      chk("reset_chal", puf_challenge, 0);
      rst_n = 1;
      set_idle();
      chk_en = 1;
      @(posedge clk); #1;

      puf_response = 8'hA5;
      for (int j = 0; j < N; j++) v[j] = 8'hA5;
      run_req(8'h3C, v, 0, 0, 0);
      chk("a_done_cycle", last_done_k, 67);
      chk("a_pulses", pulse_cnt, 7);
      chk("a_result", result, 8'hA5);
      chk("a_stable", stable, 8'hFF);
      chk("a_chal", puf_challenge, 8'h3C);
      idle_abort();

      for (int j = 0; j < N; j++) v[j] = 8'hA4 | 8'(j % 2 == 0);
      run_req(8'h11, v, 0, 0, 1);
      chk("b_result", result, 8'hA5);
      chk("b_stable", stable, 8'hFE);
      chk("b_done_cnt", done_cnt, 1);
      chk("b_pulses", pulse_cnt, 7);

      for (int j = 0; j < N; j++) v[j] = 8'hA4 | 8'(j < 3);
      run_req(8'h22, v, 0, 0, 0);
      chk("c_result", result, 8'hA4);
      chk("c_stable", stable, 8'hFE);

      for (int t = 0; t < 6; t++) begin
         for (int j = 0; j < N; j++) v[j] = 8'($urandom);
         if (t % 2 == 0) for (int j = 0; j < N; j++) v[j] = v[0] ^ (8'($urandom) & 8'h0F);
         run_req(8'($urandom), v, 0, 0, 1'($urandom_range(0, 1)));
         if (t % 3 == 0) idle_abort();
      end

      for (int j = 0; j < N; j++) v[j] = 8'($urandom);
      run_req(8'h5E, v, 1, S + E, 1);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_pulses", pulse_cnt, 2);
      chk("abort_result", result, m_res);

      for (int j = 0; j < N; j++) v[j] = 8'hFF;
      run_req(8'h99, v, 0, 0, 0);
      run_req(8'h66, v, 2, S + P + 1, 0);
      @(posedge clk); #1;
      for (int j = 0; j < N; j++) v[j] = 8'($urandom);
      run_req(8'hC3, v, 0, 0, 0);
      chk("post_rst_done_cycle", last_done_k, 67);
      chk("post_rst_done_cnt", done_cnt, 1);

      start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      k1 = 0;
      while (k1 < 20 && !done1) begin
         @(posedge clk); #1;
         k1++;
      end
      chk("small_done_cycle", k1, 6);
      chk("small_result", result1, 8'h5A);
      chk("small_stable", stable1, 8'hFF);
      chk("small_chal", chal1, 8'h77);

      @(posedge clk); #1;
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
